button_debounce_irq_ctrl: RTL

//  Avalon-MM controller for the DE2 push-button inputs: synchronises and debounces

---
 rtl/button_debounce_irq_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/button_debounce_irq_ctrl.sv
// ---------------------------------------------------------------------------
// button_debounce_irq_ctrl
//
// Purpose:
//   Avalon-MM slave for the DE2 push buttons. Each raw key goes through a
//   2-flop synchroniser and a per-bit debounce FSM. Press edges are captured
//   into sticky EDGECAP bits. A maskable, registered, level IRQ is raised
//   toward the Nios II. This block replaces a plain read-only input PIO.
//
// Register map (word addresses):
//   0 DATA     RO   debounced key levels in [WIDTH-1:0] (1 = released)
//   1 IRQMASK  RW   per-key interrupt enable
//   2 reserved      reads 0, writes ignored
//   3 EDGECAP  R/W1C sticky edge capture
//   Bits [31:WIDTH] read as 0 in every register.
//
// Ports:
//   clk         in   1      system clock
//   reset       in   1      asynchronous, active-high reset
//   address     in   2      register word address
//   chipselect  in   1      slave select
//   write       in   1      write strobe, qualified by chipselect
//   writedata   in   32     write data
//   readdata    out  32     registered read data, 1-cycle latency, no read strobe
//   in_port     in   WIDTH  raw button pins, active-low, asynchronous
//   irq         out  1      level interrupt, registered
//
// Parameters:
//   WIDTH            number of buttons (1..32)
//   DEBOUNCE_CYCLES  cycles a new level must hold before it is accepted (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Build option:
//   BUTTON_CTRL_BOTHEDGE_EN  when defined, EDGECAP captures press and release
//                            edges; otherwise press (falling) edges only.
// ---------------------------------------------------------------------------
module button_debounce_irq_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Debounce FSM encoding
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;                 // first synchroniser stage
    logic [WIDTH-1:0] sync_q;                  // second stage, feeds the FSMs
    logic [0:0]       state_q [WIDTH];
    logic [0:0]       state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic             irq_q;
    logic             irq_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic             wr_irqmask;
    logic             wr_edgecap;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic             unused_wdata;

    // Upper write-data bits have no destination when WIDTH < 32
    assign unused_wdata = ^writedata;

    // Decode the register write strobes
    always_comb begin
        wr_irqmask = 1'b0;
        wr_edgecap = 1'b0;
        if (chipselect && write) begin
            case (address)
                ADDR_IRQMASK: wr_irqmask = 1'b1;
                ADDR_EDGECAP: wr_edgecap = 1'b1;
                default: begin
                    wr_irqmask = 1'b0;
                    wr_edgecap = 1'b0;
                end
            endcase
        end else begin
            wr_irqmask = 1'b0;
            wr_edgecap = 1'b0;
        end
    end

    // Two-flop synchroniser; idles released (all ones) out of reset so that
    // keys not pressed never produce an edge on reset exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= {WIDTH{1'b1}};
            sync_q  <= {WIDTH{1'b1}};
        end else begin
            sync1_q <= in_port;
            sync_q  <= sync1_q;
        end
    end

    // Per-bit debounce FSM next state. The terminal compare caps the counter
    // so it can never wrap; a return to the accepted level while counting
    // rejects the glitch and leaves deb untouched.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync_q[i] != deb_q[i]) begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_COUNTING: begin
                    if (sync_q[i] == deb_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        deb_d[i]   = sync_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = CNT_ZERO;
                    end else begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
    end

    // Debounce FSM state, counters and accepted levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= CNT_ZERO;
            end
            deb_q      <= {WIDTH{1'b1}};
            deb_prev_q <= {WIDTH{1'b1}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    // Edge detection on the debounced level (keys are active-low, so a
    // falling edge is a press)
    always_comb begin
`ifdef BUTTON_CTRL_BOTHEDGE_EN
        edge_det = deb_prev_q ^ deb_q;
`else
        edge_det = deb_prev_q & ~deb_q;
`endif
    end

    // Mask, capture and interrupt next state. A new edge on a bit being
    // cleared in the same cycle wins, so no press is ever lost.
    always_comb begin
        if (wr_edgecap) begin
            clr_mask = writedata[WIDTH-1:0];
        end else begin
            clr_mask = {WIDTH{1'b0}};
        end
        if (wr_irqmask) begin
            irqmask_d = writedata[WIDTH-1:0];
        end else begin
            irqmask_d = irqmask_q;
        end
        edgecap_d = edge_det | (edgecap_q & ~clr_mask);
        irq_d     = |(edgecap_q & irqmask_q);
    end

    // Mask, capture and interrupt registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q <= {WIDTH{1'b0}};
            edgecap_q <= {WIDTH{1'b0}};
            irq_q     <= 1'b0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            irq_q     <= irq_d;
        end
    end

    // Read-data mux; sampled every cycle from address, upper bits zero
    always_comb begin
        readdata_d = 32'h0000_0000;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = deb_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_RSVD:    readdata_d            = 32'h0000_0000;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d            = 32'h0000_0000;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= 32'h0000_0000;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
